// File: rtl/vram_scanout_pkg.sv
// ---------------------------------------------------------------------------
// vram_scanout_pkg
// Shared video constants and types for the VRAM scanout block.
//   RST1_VECTOR / RST2_VECTOR : interrupt vectors (mid-screen / end of screen)
//   BYTES_PER_LINE            : VRAM bytes per active line (256 pixels / 8)
//   ACTIVE_W / ACTIVE_H       : visible area size in pixels and lines
//   COUNT_W / ADDR_W          : counter and VRAM address widths
// ---------------------------------------------------------------------------
package vram_scanout_pkg;

  localparam logic [7:0] RST1_VECTOR    = 8'hCF;
  localparam logic [7:0] RST2_VECTOR    = 8'hD7;
  localparam int         BYTES_PER_LINE = 32;
  localparam int         ACTIVE_W       = 256;
  localparam int         ACTIVE_H       = 224;
  localparam int         COUNT_W        = 9;
  localparam int         ADDR_W         = 13;

  typedef logic [COUNT_W-1:0] count_t;

  // Which pending interrupt is currently being presented to the CPU.
  typedef enum logic [1:0] {
    IRQ_NONE = 2'd0,
    IRQ_MID  = 2'd1,
    IRQ_END  = 2'd2
  } irq_src_e;

  // Vector the CPU sees for a given presented source; with nothing pending
  // the mid-screen vector is shown so the output has a defined idle value.
  function automatic logic [7:0] vector_for(input irq_src_e src);
    return (src == IRQ_END) ? RST2_VECTOR : RST1_VECTOR;
  endfunction

endpackage

// File: rtl/video_timing.sv
// ---------------------------------------------------------------------------
// video_timing
// Raster counters plus registered sync/display-enable generation.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   enable          : scanout run; low holds the raster at (0,0), outputs 0
//   advance         : one pixel step this clock (pix_ce & enable)
//   hcount, vcount  : current raster position
//   active          : current position lies inside the visible area
//   line_start      : this advance edge wraps hcount to 0
//   next_vcount     : line number that will be entered at the wrap
//   de, hsync, vsync: registered, describe the position of the last advance
// ---------------------------------------------------------------------------
module video_timing
  import vram_scanout_pkg::*;
#(
  parameter int H_TOTAL  = 320,
  parameter int V_TOTAL  = 262,
  parameter int HS_START = 272,
  parameter int HS_LEN   = 24,
  parameter int VS_START = 234,
  parameter int VS_LEN   = 3
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   enable,
  input  logic   advance,
  output count_t hcount,
  output count_t vcount,
  output logic   active,
  output logic   line_start,
  output count_t next_vcount,
  output logic   de,
  output logic   hsync,
  output logic   vsync
);

  localparam count_t H_LAST = count_t'(H_TOTAL - 1);
  localparam count_t V_LAST = count_t'(V_TOTAL - 1);
  localparam count_t HS_LO  = count_t'(HS_START);
  localparam count_t HS_HI  = count_t'(HS_START + HS_LEN);
  localparam count_t VS_LO  = count_t'(VS_START);
  localparam count_t VS_HI  = count_t'(VS_START + VS_LEN);
  localparam count_t ACT_W  = count_t'(ACTIVE_W);
  localparam count_t ACT_H  = count_t'(ACTIVE_H);

  logic last_h;
  logic last_v;
  logic hs_now;
  logic vs_now;

  always_comb begin
    last_h      = (hcount == H_LAST);
    last_v      = (vcount == V_LAST);
    active      = (hcount < ACT_W) && (vcount < ACT_H);
    hs_now      = (hcount >= HS_LO) && (hcount < HS_HI);
    vs_now      = (vcount >= VS_LO) && (vcount < VS_HI);
    line_start  = advance && last_h;
    next_vcount = last_v ? '0 : vcount + count_t'(1);
  end

  // The sync/de registers capture the position being left, so they lag the
  // counters by one advance and line up with the pixel leaving the shifter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hcount <= '0;
      vcount <= '0;
      de     <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else if (!enable) begin
      hcount <= '0;
      vcount <= '0;
      de     <= 1'b0;
      hsync  <= 1'b0;
      vsync  <= 1'b0;
    end else if (advance) begin
      hcount <= last_h ? '0 : hcount + count_t'(1);
      if (last_h) begin
        vcount <= next_vcount;
      end
      de    <= active;
      hsync <= hs_now;
      vsync <= vs_now;
    end
  end

endmodule

// File: rtl/vram_scanout.sv
// ---------------------------------------------------------------------------
// vram_scanout
// 1-bpp VRAM scanout with mid-screen and end-of-screen interrupts.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   pix_ce            : pixel advance enable
//   enable            : scanout run; low parks the raster and clears irqs
//   vram_addr         : VRAM byte address for the current position
//   vram_data         : combinational read data for vram_addr
//   pixel, de         : pixel value (0 outside active area), display enable
//   hsync, vsync      : active-high sync pulses
//   hcount, vcount    : current raster position
//   irq_pending       : at least one interrupt is waiting
//   irq_vector        : RST vector of the presented interrupt
//   irq_ack           : single-cycle acknowledge of the presented interrupt
// ---------------------------------------------------------------------------
module vram_scanout
  import vram_scanout_pkg::*;
#(
  parameter int H_TOTAL  = 320,
  parameter int V_TOTAL  = 262,
  parameter int HS_START = 272,
  parameter int HS_LEN   = 24,
  parameter int VS_START = 234,
  parameter int VS_LEN   = 3,
  parameter int MID_LINE = 96
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pix_ce,
  input  logic              enable,
  output logic [ADDR_W-1:0] vram_addr,
  input  logic [7:0]        vram_data,
  output logic              pixel,
  output logic              de,
  output logic              hsync,
  output logic              vsync,
  output logic [8:0]        hcount,
  output logic [8:0]        vcount,
  output logic              irq_pending,
  output logic [7:0]        irq_vector,
  input  logic              irq_ack
);

  logic     advance;
  logic     active;
  logic     line_start;
  count_t   next_vcount;
  logic     de_raw;
  logic [7:0] shift_q;
  logic     pend_mid;
  logic     pend_end;
  logic     mid_set;
  logic     end_set;
  logic     ack_mid;
  logic     ack_end;
  irq_src_e presented;

  assign advance = pix_ce & enable;

  video_timing #(
    .H_TOTAL  (H_TOTAL),
    .V_TOTAL  (V_TOTAL),
    .HS_START (HS_START),
    .HS_LEN   (HS_LEN),
    .VS_START (VS_START),
    .VS_LEN   (VS_LEN)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .advance     (advance),
    .hcount      (hcount),
    .vcount      (vcount),
    .active      (active),
    .line_start  (line_start),
    .next_vcount (next_vcount),
    .de          (de_raw),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  // Row-major byte map, 32 bytes per line; only meaningful in the active area.
  assign vram_addr = ADDR_W'(int'(vcount) * BYTES_PER_LINE + int'(hcount[7:3]));

  // Pixel 0 of each byte is its bit 0, so the shifter moves right and the
  // LSB is always the pixel for the position just advanced past.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_q <= 8'h00;
    end else if (!enable) begin
      shift_q <= 8'h00;
    end else if (advance && active) begin
      if (hcount[2:0] == 3'd0) begin
        shift_q <= vram_data;
      end else begin
        shift_q <= {1'b0, shift_q[7:1]};
      end
    end
  end

  assign de    = de_raw;
  assign pixel = shift_q[0] & de_raw;

  // Interrupt events fire on the advance that enters column 0 of the line.
  // End-of-screen outranks mid-screen, and an ack only clears the source
  // that is currently on irq_vector.
  always_comb begin
    mid_set   = line_start && (next_vcount == count_t'(MID_LINE));
    end_set   = line_start && (next_vcount == count_t'(ACTIVE_H));
    presented = IRQ_NONE;
    if (pend_end) begin
      presented = IRQ_END;
    end else if (pend_mid) begin
      presented = IRQ_MID;
    end
    ack_end = irq_ack && (presented == IRQ_END);
    ack_mid = irq_ack && (presented == IRQ_MID);
  end

  // A set that coincides with an ack of the same flag wins, so the event is
  // never lost; repeat sets while pending simply leave the flag high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_mid <= 1'b0;
      pend_end <= 1'b0;
    end else if (!enable) begin
      pend_mid <= 1'b0;
      pend_end <= 1'b0;
    end else begin
      pend_mid <= mid_set | (pend_mid & ~ack_mid);
      pend_end <= end_set | (pend_end & ~ack_end);
    end
  end

  assign irq_pending = pend_mid | pend_end;
  assign irq_vector  = vector_for(presented);

endmodule

// File: tb/tb_vram_scanout.sv
// ---------------------------------------------------------------------------
// tb_vram_scanout
// Directed bench for vram_scanout. The raster is shortened (264 x 228, mid
// interrupt on line 4) so a complete frame plus the wrap into the next one
// fits in a short run; the active area is still the full 256 x 224.
// ---------------------------------------------------------------------------
module tb_vram_scanout;

  localparam int H_T  = 264;
  localparam int V_T  = 228;
  localparam int HS_S = 258;
  localparam int HS_L = 4;
  localparam int VS_S = 225;
  localparam int VS_L = 2;
  localparam int MID  = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        pix_ce = 1'b0;
  logic        enable = 1'b0;
  logic        irq_ack = 1'b0;
  logic [12:0] vram_addr;
  logic [7:0]  vram_data;
  logic        pixel;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [8:0]  hcount;
  logic [8:0]  vcount;
  logic        irq_pending;
  logic [7:0]  irq_vector;

  logic [7:0]  mem [8192];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign vram_data = mem[vram_addr];

  vram_scanout #(
    .H_TOTAL  (H_T),
    .V_TOTAL  (V_T),
    .HS_START (HS_S),
    .HS_LEN   (HS_L),
    .VS_START (VS_S),
    .VS_LEN   (VS_L),
    .MID_LINE (MID)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_ce      (pix_ce),
    .enable      (enable),
    .vram_addr   (vram_addr),
    .vram_data   (vram_data),
    .pixel       (pixel),
    .de          (de),
    .hsync       (hsync),
    .vsync       (vsync),
    .hcount      (hcount),
    .vcount      (vcount),
    .irq_pending (irq_pending),
    .irq_vector  (irq_vector),
    .irq_ack     (irq_ack)
  );

  // Expected pixel at (h,v): bit (h mod 8) of byte v*32 + h/8, 0 off-screen.
  function automatic logic expPix(input int h, input int v);
    logic [7:0] b;
    if (h < 256 && v < 224) begin
      b = mem[v * 32 + h / 8];
      return b[h % 8];
    end
    return 1'b0;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Drive the inputs, then move to 1 time unit after the next rising edge.
  task automatic applyStimulus(input logic en, input logic ce, input logic ack);
    enable  = en;
    pix_ce  = ce;
    irq_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic waitPos(input int h, input int v, input int budget);
    int n;
    n = 0;
    while (!(hcount == 9'(h) && vcount == 9'(v)) && n < budget) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end
    checkOutput($sformatf("reach_%0d_%0d", h, v), {14'd0, hcount, vcount},
                {14'd0, 9'(h), 9'(v)});
  endtask

  task automatic waitIrq(input string tag, input int h, input int v,
                         input int budget);
    int n;
    n = 0;
    while (!irq_pending && n < budget) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      n++;
    end
    checkOutput({tag, "_pending"}, 32'(irq_pending), 32'd1);
    checkOutput({tag, "_pos"}, {14'd0, hcount, vcount}, {14'd0, 9'(h), 9'(v)});
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    for (int i = 0; i < 8192; i++) begin
      mem[i] = 8'((i * 37) ^ (i >> 5));
    end
    mem[0] = 8'h01;
    mem[1] = 8'hA5;

    // Reset state
    rst_n = 1'b0;
    #12;
    checkOutput("rst_hcount", 32'(hcount), 32'd0);
    checkOutput("rst_vcount", 32'(vcount), 32'd0);
    checkOutput("rst_pixel", 32'(pixel), 32'd0);
    checkOutput("rst_de", 32'(de), 32'd0);
    checkOutput("rst_hsync", 32'(hsync), 32'd0);
    checkOutput("rst_vsync", 32'(vsync), 32'd0);
    checkOutput("rst_irq_pending", 32'(irq_pending), 32'd0);
    checkOutput("rst_irq_vector", 32'(irq_vector), 32'hCF);
    rst_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0);

    // Line 0 with pix_ce held high: pixel, de and hsync per column
    $display("[TB] line 0 scan");
    for (int h = 0; h < H_T; h++) begin
      applyStimulus(1'b1, 1'b1, 1'b0);
      checkOutput($sformatf("l0_pixel_h%0d", h), 32'(pixel), 32'(expPix(h, 0)));
      checkOutput($sformatf("l0_de_h%0d", h), 32'(de), 32'(h < 256));
      checkOutput($sformatf("l0_hsync_h%0d", h), 32'(hsync),
                  32'(h >= HS_S && h < HS_S + HS_L));
    end
    checkOutput("wrap_hcount", 32'(hcount), 32'd0);
    checkOutput("wrap_vcount", 32'(vcount), 32'd1);

    // Mid-screen interrupt, ack, address mapping, end-of-screen interrupt
    waitIrq("mid_irq", 0, MID, 5000);
    checkOutput("mid_vector", 32'(irq_vector), 32'hCF);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("mid_ack_pending", 32'(irq_pending), 32'd0);

    waitPos(13, 5, 5000);
    checkOutput("addr_13_5", 32'(vram_addr), 32'd161);
    waitPos(255, 223, 70000);
    checkOutput("addr_255_223", 32'(vram_addr), 32'd7167);
    checkOutput("no_irq_before_end", 32'(irq_pending), 32'd0);

    waitIrq("end_irq", 0, 224, 1000);
    checkOutput("end_vector", 32'(irq_vector), 32'hD7);

    // Vertical sync window edges
    waitPos(0, 225, 1000);
    checkOutput("vsync_before", 32'(vsync), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("vsync_first", 32'(vsync), 32'd1);
    waitPos(0, 227, 1000);
    checkOutput("vsync_last", 32'(vsync), 32'd1);
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("vsync_after", 32'(vsync), 32'd0);

    // Next frame: mid fires while end is still pending
    waitPos(0, MID, 5000);
    checkOutput("both_pending", 32'(irq_pending), 32'd1);
    checkOutput("both_vector", 32'(irq_vector), 32'hD7);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("ack1_pending", 32'(irq_pending), 32'd1);
    checkOutput("ack1_vector", 32'(irq_vector), 32'hCF);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("ack2_pending", 32'(irq_pending), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1);
    checkOutput("idle_ack_pending", 32'(irq_pending), 32'd0);
    checkOutput("idle_ack_vector", 32'(irq_vector), 32'hCF);

    // Asynchronous reset in the middle of a visible line
    waitPos(100, 6, 1000);
    checkOutput("pre_rst_de", 32'(de), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("arst_hcount", 32'(hcount), 32'd0);
    checkOutput("arst_vcount", 32'(vcount), 32'd0);
    checkOutput("arst_de", 32'(de), 32'd0);
    checkOutput("arst_pixel", 32'(pixel), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b0);
    rst_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0);
    checkOutput("post_rst_hcount", 32'(hcount), 32'd1);
    checkOutput("post_rst_vcount", 32'(vcount), 32'd0);
    checkOutput("post_rst_pixel", 32'(pixel), 32'd1);
    checkOutput("post_rst_irq", 32'(irq_pending), 32'd0);

    // Scanout disabled: raster parked, outputs low
    applyStimulus(1'b0, 1'b1, 1'b0);
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("dis_hcount", 32'(hcount), 32'd0);
    checkOutput("dis_vcount", 32'(vcount), 32'd0);
    checkOutput("dis_de", 32'(de), 32'd0);
    checkOutput("dis_pixel", 32'(pixel), 32'd0);

    // Resume with pix_ce on every other clock: same pixels, half rate
    $display("[TB] half-rate scan of lines 0-1");
    for (int v = 0; v < 2; v++) begin
      for (int h = 0; h < H_T; h++) begin
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput($sformatf("half_pixel_%0d_%0d", h, v), 32'(pixel),
                    32'(expPix(h, v)));
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput($sformatf("half_hold_pixel_%0d_%0d", h, v), 32'(pixel),
                    32'(expPix(h, v)));
        checkOutput($sformatf("half_hold_h_%0d_%0d", h, v), 32'(hcount),
                    32'((h + 1) % H_T));
      end
    end
    checkOutput("half_end_vcount", 32'(vcount), 32'd2);
    checkOutput("half_end_hcount", 32'(hcount), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
